// File: rtl/vga_pkg.sv
// Shared VGA frame-store definitions: raster geometry defaults, pixel type, writer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int STRIDE_DEF   = 1024;
    localparam int ADDR_W_DEF   = 20;

    // 24-bit pixel, red in the top byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } fw_state_t;

endpackage

// File: rtl/frame_writer_if.sv
// Handshake bundles around frame_writer: raster pixel stream in, frame-memory write port out.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the stream, en/ready on the write port.

// Pixel stream: master drives valid/data/sof, slave returns ready.
interface pix_stream_if;
    import vga_pkg::*;

    logic   valid;
    logic   ready;
    rgb24_t data;
    logic   sof;

    modport master (output valid, output data, output sof, input ready);
    modport slave  (input valid, input data, input sof, output ready);
endinterface

// Memory write port: master drives en/addr/data, slave returns ready.
interface mem_wr_if #(
    parameter int ADDR_W = vga_pkg::ADDR_W_DEF
);
    import vga_pkg::*;

    logic              en;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    rgb24_t            data;

    modport master (output en, output addr, output data, input ready);
    modport slave  (input en, input addr, input data, output ready);
endinterface

// File: rtl/raster_counter.sv
// Raster x/y position counter with end-of-line and last-line flags.
// Latency: position updates on the clock edge after clr/restart/adv.
// Backpressure: none; advances only when told to.
//
// Ports: clk, rst_n; clr (back to 0,0), restart (position just after pixel 0,0),
// adv (step one pixel); x, y current position; line_end (x at last column),
// last_line (y at last row).
module raster_counter #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE_DEF,
    parameter int XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    parameter int YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          restart,
    input  logic          adv,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_end,
    output logic          last_line
);

    assign line_end  = (x == XW'(H_ACTIVE - 1));
    assign last_line = (y == YW'(V_ACTIVE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            // Pixel (0,0) has just been consumed; point at the one after it.
            if (H_ACTIVE == 1) begin
                x <= '0;
                y <= (V_ACTIVE > 1) ? YW'(1) : '0;
            end else begin
                x <= XW'(1);
                y <= '0;
            end
        end else if (adv) begin
            if (line_end) begin
                x <= '0;
                y <= last_line ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Raster pixel stream to frame-store writer: one memory write per pixel at y*STRIDE + x.
// Latency: beat accepted in cycle N appears on the write port in cycle N+1.
// Backpressure: one registered output stage; s.ready = ~wr.en | wr.ready, so a stalled write holds and blocks input.
//
// Ports: clk, rst_n; capture_en (arms capture of the next sof frame, sampled in IDLE);
// err_clr (clears sof_err); s (pixel stream slave); wr (memory write master);
// busy (frame in progress); frame_done (pulse when the last pixel is accepted);
// sof_err (sticky, sof arrived mid-frame).
module frame_writer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int STRIDE   = STRIDE_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    capture_en,
    input  logic    err_clr,
    pix_stream_if.slave s,
    mem_wr_if.master    wr,
    output logic    busy,
    output logic    frame_done,
    output logic    sof_err
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    // A 1x1 frame ends on its sof beat and never enters WRITE.
    localparam bit SINGLE = (H_ACTIVE == 1) && (V_ACTIVE == 1);

    fw_state_t         state_q, state_d;
    logic              accept;
    logic              load;
    logic [ADDR_W-1:0] load_addr;
    logic              cnt_clr, cnt_restart, cnt_adv;
    logic              err_set;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              line_end, last_line, frame_end;
    logic [ADDR_W-1:0] pix_addr;

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    rgb24_t            wr_data_q;
    logic              sof_err_q;

    raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_raster (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .restart   (cnt_restart),
        .adv       (cnt_adv),
        .x         (x),
        .y         (y),
        .line_end  (line_end),
        .last_line (last_line)
    );

    // Output register frees up in the same cycle it drains, so writes stream back to back.
    assign s.ready   = ~wr_en_q | wr.ready;
    assign accept    = s.valid & s.ready;
    assign frame_end = line_end & last_line;
    // Power-of-two STRIDE folds the multiply into a shift.
    assign pix_addr  = ADDR_W'(y) * ADDR_W'(STRIDE) + ADDR_W'(x);

    assign wr.en   = wr_en_q;
    assign wr.addr = wr_addr_q;
    assign wr.data = wr_data_q;
    assign busy    = (state_q == ST_WRITE);
    assign sof_err = sof_err_q;

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        load_addr   = '0;
        cnt_clr     = 1'b0;
        cnt_restart = 1'b0;
        cnt_adv     = 1'b0;
        err_set     = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Beats without an armed sof still handshake but are dropped.
                if (accept && s.sof && capture_en) begin
                    load = 1'b1;
                    if (SINGLE) begin
                        frame_done = 1'b1;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_restart = 1'b1;
                        state_d     = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    load = 1'b1;
                    if (s.sof) begin
                        // Resynchronise: this beat becomes pixel (0,0) of a new frame.
                        err_set     = 1'b1;
                        cnt_restart = 1'b1;
                    end else begin
                        load_addr = pix_addr;
                        if (frame_end) begin
                            frame_done = 1'b1;
                            cnt_clr    = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            cnt_adv = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (load) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= load_addr;
            wr_data_q <= s.data;
        end else if (wr.ready) begin
            wr_en_q   <= 1'b0;
        end
    end

    // A new sof error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sof_err_q <= 1'b0;
        end else if (err_set) begin
            sof_err_q <= 1'b1;
        end else if (err_clr) begin
            sof_err_q <= 1'b0;
        end
    end

endmodule
